// File: rtl/adder_8_serial_ctrl.sv
// Bit-serial 8-bit adder: one 2-bit full-adder slice reused over 4 cycles, LSB slice first.
// Optional accumulate mode (acc port, sum fed back as operand B) under `ADDER_8_SERIAL_ACC_EN.
module adder_8_serial_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
`ifdef ADDER_8_SERIAL_ACC_EN
    input  logic       acc,
`endif
    output logic       busy,
    output logic       done,
    output logic [7:0] sum,
    output logic       out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic        carry_q, carry_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [7:0]  sum_q, sum_d;
    logic        out_q, out_d;
    logic [2:0]  slice;
    logic        acc_sel;

`ifdef ADDER_8_SERIAL_ACC_EN
    assign acc_sel = acc;
`else
    assign acc_sel = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        out_d   = out_q;
        slice   = {1'b0, a_q[{idx_q, 1'b0} +: 2]} + {1'b0, b_q[{idx_q, 1'b0} +: 2]}
                + {2'b00, carry_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = CALC;
                    // Accumulate keeps the previous result visible and feeds it in as B.
                    if (acc_sel) begin
                        b_d = sum_q;
                    end else begin
                        b_d   = b;
                        sum_d = '0;
                        out_d = 1'b0;
                    end
                end
            end
            CALC: begin
                sum_d[{idx_q, 1'b0} +: 2] = slice[1:0];
                carry_d = slice[2];
                idx_d   = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    out_d   = slice[2];
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            out_q   <= out_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign out  = out_q;

endmodule

// File: tb/tb_adder_8_serial_ctrl.sv
// Scoreboard bench for adder_8_serial_ctrl: stimulus pushes expected {out,sum} and done cycle,
// an independent negedge monitor pops and compares on every done pulse.
module tb_adder_8_serial_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
`ifdef ADDER_8_SERIAL_ACC_EN
    logic       acc_drv;
`endif
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       out;

    typedef struct {
        logic [8:0]  res;
        int unsigned cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [8:0]  model_res;
    int unsigned cyc;
    int unsigned n_checks;
    int unsigned n_pass;

    adder_8_serial_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef ADDER_8_SERIAL_ACC_EN
        .acc   (acc_drv),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding operation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                check("done_unexpected", {31'b0, done}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("result", {23'b0, out, sum}, {23'b0, e.res});
                check("done_latency", cyc, e.cyc);
            end
        end
    end

    // mode 0: quiet, 1: random start/operand noise while busy, 2: start re-pulsed with a=AA
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic icin,
                          input logic iacc, input int unsigned mode);
        logic [7:0] opb;
        logic [8:0] res;
        logic [8:0] prev;
        exp_t       e;
        opb  = iacc ? model_res[7:0] : ib;
        res  = {1'b0, ia} + {1'b0, opb} + {8'b0, icin};
        prev = model_res;
        a = ia; b = ib; cin = icin; start = 1'b1;
`ifdef ADDER_8_SERIAL_ACC_EN
        acc_drv = iacc;
`endif
        @(posedge clk);
        @(negedge clk);
        model_res = res;
        e.res = res;
        e.cyc = cyc + 4;
        exp_q.push_back(e);
        check("busy_after_accept", {31'b0, busy}, 32'd1);
        check("sum_at_accept", {23'b0, out, sum}, iacc ? {23'b0, prev} : 32'd0);
        start = 1'b0;
`ifdef ADDER_8_SERIAL_ACC_EN
        acc_drv = 1'b0;
`endif
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (mode == 1) begin
                start = 1'($urandom_range(0, 1));
                a     = 8'($urandom);
                b     = 8'($urandom);
                cin   = 1'($urandom_range(0, 1));
`ifdef ADDER_8_SERIAL_ACC_EN
                acc_drv = 1'($urandom_range(0, 1));
`endif
            end else if (mode == 2) begin
                start = (k == 1 || k == 4);
                a     = 8'hAA;
            end
        end
        @(negedge clk);
        check("busy_low_after_done", {31'b0, busy}, 32'd0);
        check("done_low_after_done", {31'b0, done}, 32'd0);
        start = 1'b0;
`ifdef ADDER_8_SERIAL_ACC_EN
        acc_drv = 1'b0;
`endif
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        model_res = '0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef ADDER_8_SERIAL_ACC_EN
        acc_drv = 1'b0;
`endif
        #2;
        check("reset_sum", {23'b0, out, sum}, 32'd0);
        check("reset_busy_done", {30'b0, busy, done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 0);
        run_op(8'h10, 8'h01, 1'b0, 1'b0, 2);
        run_op(8'h00, 8'h00, 1'b0, 1'b0, 0);

        // Asynchronous reset mid-operation: outputs clear at once, no done follows.
        a = 8'hF0; b = 8'h0F; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("abort_sum", {23'b0, out, sum}, 32'd0);
        check("abort_busy_done", {30'b0, busy, done}, 32'd0);
        model_res = '0;
        @(negedge clk);
        rst = 1'b0;
        run_op(8'hF0, 8'h0F, 1'b0, 1'b0, 0);
        run_op(8'hF0, 8'h0F, 1'b1, 1'b0, 0);

`ifdef ADDER_8_SERIAL_ACC_EN
        run_op(8'h20, 8'h00, 1'b0, 1'b0, 0);
        run_op(8'h30, 8'h00, 1'b0, 1'b1, 0);
        run_op(8'hC0, 8'h00, 1'b0, 1'b1, 0);
`endif

        for (int n = 0; n < 40; n++) begin
            logic iacc;
`ifdef ADDER_8_SERIAL_ACC_EN
            iacc = 1'($urandom_range(0, 1));
`else
            iacc = 1'b0;
`endif
            run_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), iacc, 1);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) @(negedge clk);
        end

        repeat (8) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
